data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning storage size in 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter LATENCY, default 3, meaning cycles from request acceptance to completion (at least 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port memRead, input, 1 bit: MEM-stage load request.
REQ-006 SHALL have port memWrite, input, 1 bit: MEM-stage store request.
REQ-007 SHALL have port address, input, 32 bits: byte address from the ALU result.
REQ-008 SHALL have port writeData, input, 32 bits: store data.
REQ-009 SHALL have port readData, output, 32 bits: registered load result.
REQ-010 SHALL have port stall, output, 1 bit: pipeline freeze request.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port misaligned, output, 1 bit: completed access had address[1:0] != 0.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-014 SHALL accept a request in IDLE when memRead or memWrite is 1.
- On accept, latch address, writeData and op.
- Load counter with LATENCY-1.
REQ-015 SHALL resolve memRead=memWrite=1 as a write; the read is ignored.
REQ-016 SHALL transition on accept to ACCESS if LATENCY>1, else directly to DONE.
REQ-017 SHALL decrement the counter each ACCESS cycle and go to DONE on the edge where the counter is 1.
REQ-018 SHALL drive stall combinationally: 1 when (IDLE and request) or ACCESS, else 0.
- Accept at cycle t gives stall=1 for cycles t..t+LATENCY-1.
- stall=0 at cycle t+LATENCY.
REQ-019 SHALL hold done=1 only in the DONE cycle (t+LATENCY).
REQ-020 SHALL return DONE to IDLE unconditionally after one cycle.
- Request inputs are not sampled in DONE.
- No request is re-accepted while the pipeline advances.
REQ-021 SHALL compute the word index as latched address[log2(DEPTH)+1:2]; upper address bits are ignored, so the address space wraps.
REQ-022 SHALL commit an aligned write to the array on the edge entering DONE.
REQ-023 SHALL load readData from the array on the edge entering DONE for an aligned read.
- readData holds its value until the next completed read.
- Writes leave readData unchanged.
REQ-024 SHALL handle a misaligned access as follows:
- Suppress the write.
- Set readData to 0 for reads.
- Assert misaligned in the DONE cycle only.
REQ-025 SHALL make a read after a write to the same word return the new data, since accesses are serialized.
REQ-026 SHALL ignore request inputs during ACCESS; latched values are used.

Reset
REQ-027 SHALL, on reset=1 at a clock edge:
- Set state to IDLE and counter to 0.
- Set readData to 0, done to 0, misaligned to 0.
- Clear all DEPTH words to 0.
REQ-028 SHALL abort an in-flight access on reset: a pending write is discarded and done does not pulse.
REQ-029 SHALL give reset priority over all other events in the same cycle; stall=0 in the reset cycle.

Verification
REQ-030 SHALL cover aligned store then load: write 0xDEADBEEF to 0x10, then read 0x10.
- Each access: stall high 3 cycles, done pulse on the 4th.
- readData=0xDEADBEEF after the read.
REQ-031 SHALL cover misaligned store to 0x12 followed by a read of 0x10.
- misaligned=1 with done.
- Read returns the previous contents (0 after reset).
REQ-032 SHALL cover wrap-around with DEPTH=256: write 0x1 to 0x400, read 0x000 -> readData=0x1.
REQ-033 SHALL cover memRead=memWrite=1 with writeData=0x5A5A5A5A at 0x20.
- Performs the write; readData unchanged.
- A later read of 0x20 returns 0x5A5A5A5A.
REQ-034 SHALL cover reset asserted during ACCESS of a write of 0x77 to 0x30.
- No done pulse; stall=0 next cycle.
- A later read of 0x30 returns 0.
REQ-035 SHALL cover LATENCY=1 back-to-back requests held high: each completes in 2 cycles (stall 1, done 1) with no duplicate acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the MEM stage. A load or store is
// accepted in IDLE, held for LATENCY cycles while the pipeline is stalled,
// and completed with a single-cycle done pulse. Misaligned accesses complete
// normally. They suppress the write, return zero for reads, and flag misaligned.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        done,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic [31:0]     rdata_q;
    logic            done_q;
    logic            mis_q;
    logic [31:0]     mem_q [DEPTH];

    logic            req;
    logic            fin_go;
    logic            fin_write;
    logic [AW+1:0]   fin_addr;
    logic [31:0]     fin_wdata;
    logic            fin_mis;
    logic [AW-1:0]   fin_idx;

    // Upper address bits do not select storage; the address space wraps.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^address[31:AW+2];

    // A write takes priority when both request lines are high.
    assign req = memRead | memWrite;

    // Select the access that completes on this edge. With LATENCY=1 it
    // completes on the accept edge, so it uses the live inputs rather than
    // the latched copy.
    always_comb begin
        fin_go    = 1'b0;
        fin_write = write_q;
        fin_addr  = addr_q;
        fin_wdata = wdata_q;
        if (state_q == IDLE && req && LATENCY == 1) begin
            fin_go    = 1'b1;
            fin_write = memWrite;
            fin_addr  = address[AW+1:0];
            fin_wdata = writeData;
        end else if (state_q == ACCESS && cnt_q == CW'(1)) begin
            fin_go = 1'b1;
        end
    end

    assign fin_mis = (fin_addr[1:0] != 2'b00);
    assign fin_idx = fin_addr[AW+1:2];

    // Control FSM with registered readData, done and misaligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= fin_go;
            mis_q  <= fin_go & fin_mis;
            if (fin_go && !fin_write) begin
                rdata_q <= fin_mis ? '0 : mem_q[fin_idx];
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= address[AW+1:0];
                        wdata_q <= writeData;
                        write_q <= memWrite;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= (LATENCY > 1) ? ACCESS : DONE;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage array: cleared on reset, aligned writes commit entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fin_go && fin_write && !fin_mis) begin
            mem_q[fin_idx] <= fin_wdata;
        end
    end

    assign stall      = !reset && ((state_q == IDLE && req) || state_q == ACCESS);
    assign readData   = rdata_q;
    assign done       = done_q;
    assign misaligned = mis_q;

endmodule
